// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin two-master arbiter and sequencer for the single-port cache
//
// Purpose: grants read/write requests from two masters to the single-port cache
// controller in round-robin order, drives the cache start/payload handshake,
// follows cache_busy to completion and returns a one-cycle done pulse (plus read
// data) to the master that was granted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN, rdN, addrN, wdataN request level and payload of master N (held until doneN)
//   doneN, rdataN            completion pulse and read result of master N
//   grant_id, busy_o         owning master and transaction-in-flight flag
//   cache_start              one-cycle start pulse to the cache
//   cache_address/_write_data/_read_operation  latched payload towards the cache
//   cache_busy, cache_read_data                 cache status and read result

module cache_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd0,
  input  logic              rd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              grant_id,
  output logic              busy_o,
  output logic              cache_start,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_write_data,
  output logic              cache_read_operation,
  input  logic              cache_busy,
  input  logic [DATA_W-1:0] cache_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  // Last counter value spent in WAIT_BUSY before the op is taken as complete.
  localparam logic [3:0] TIMEOUT_LAST = 4'(BUSY_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_id_q, grant_id_d;
  logic              busy_o_q, busy_o_d;
  logic              cache_start_q, cache_start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              winner;
  logic              enter_resp;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    grant_id_d    = grant_id_q;
    busy_o_d      = busy_o_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    cache_start_d = 1'b0;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    winner        = 1'b0;
    enter_resp    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Holding off while the cache is busy lets an op that was in flight
        // across a reset drain before we reuse the port.
        if (!cache_busy && (req0 || req1)) begin
          // On contention the master that did not win last time goes first.
          winner        = (req0 && req1) ? ~last_grant_q : req1;
          grant_id_d    = winner;
          addr_d        = winner ? addr1  : addr0;
          wdata_d       = winner ? wdata1 : wdata0;
          rd_d          = winner ? rd1    : rd0;
          busy_o_d      = 1'b1;
          cache_start_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'd0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A cache that never reports busy is treated as having finished
        // after BUSY_TIMEOUT quiet cycles.
        if (cache_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!cache_busy) begin
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        last_grant_d = grant_id_q;
        busy_o_d     = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is captured on the same edge that raises done, so rdataN is
    // already valid during the done cycle.
    if (enter_resp) begin
      state_d = S_RESP;
      if (grant_id_q) begin
        done1_d = 1'b1;
        if (rd_q) begin
          rdata1_d = cache_read_data;
        end
      end else begin
        done0_d = 1'b1;
        if (rd_q) begin
          rdata0_d = cache_read_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= 4'd0;
      grant_id_q    <= 1'b0;
      busy_o_q      <= 1'b0;
      cache_start_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      grant_id_q    <= grant_id_d;
      busy_o_q      <= busy_o_d;
      cache_start_q <= cache_start_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign done0                = done0_q;
  assign done1                = done1_q;
  assign rdata0               = rdata0_q;
  assign rdata1               = rdata1_q;
  assign grant_id             = grant_id_q;
  assign busy_o               = busy_o_q;
  assign cache_start          = cache_start_q;
  assign cache_address        = addr_q;
  assign cache_write_data     = wdata_q;
  assign cache_read_operation = rd_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - self-checking bench for cache_port_arbiter

module tb_cache_port_arbiter;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_v, req1_v, rd0_v, rd1_v;
  logic [ADDR_W-1:0] addr0_v, addr1_v;
  logic [DATA_W-1:0] wdata0_v, wdata1_v;
  logic              done0, done1, grant_id, busy_o, cache_start, cache_read_operation;
  logic [DATA_W-1:0] rdata0, rdata1, cache_write_data, cache_read_data;
  logic [ADDR_W-1:0] cache_address;
  logic              model_busy, force_busy;
  logic              cache_busy;

  assign cache_busy = model_busy | force_busy;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0_v), .req1(req1_v), .rd0(rd0_v), .rd1(rd1_v),
    .addr0(addr0_v), .addr1(addr1_v), .wdata0(wdata0_v), .wdata1(wdata1_v),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .grant_id(grant_id), .busy_o(busy_o), .cache_start(cache_start),
    .cache_address(cache_address), .cache_write_data(cache_write_data),
    .cache_read_operation(cache_read_operation),
    .cache_busy(cache_busy), .cache_read_data(cache_read_data)
  );

  typedef struct {
    int          master;
    bit          rd;
    logic [7:0]  addr;
    logic [7:0]  data;
    int          lat;
  } sb_t;

  typedef struct {
    bit          r0;
    bit          rd0;
    logic [7:0]  a0;
    logic [7:0]  w0;
    bit          r1;
    bit          rd1;
    logic [7:0]  a1;
    logic [7:0]  w1;
    int          blen;
    int          first;
  } vec_t;

  sb_t        sb_q[$];
  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] exp_rdata[2];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         busy_len = 2;
  int         m_cnt;
  bit         prev_start, prev_done, active;
  logic [7:0] s_addr, s_wdata, m_addr, m_wdata;
  logic       s_rd, m_rd;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input int m, input bit rd, input logic [7:0] a, input logic [7:0] w,
                      input int blen);
    sb_t e;
    e.master = m;
    e.rd     = rd;
    e.addr   = a;
    if (rd) begin
      e.data = ref_mem[a];
    end else begin
      ref_mem[a] = w;
      e.data     = w;
    end
    e.lat = (blen == 0) ? BUSY_TIMEOUT + 1 : blen + 1;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int m, input bit rd, input logic [7:0] a, input logic [7:0] w);
    if (m == 0) begin
      rd0_v = rd; addr0_v = a; wdata0_v = w; req0_v = 1'b1;
    end else begin
      rd1_v = rd; addr1_v = a; wdata1_v = w; req1_v = 1'b1;
    end
  endtask

  task automatic wait_done(input int m, input bit drop);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = (m == 0) ? done0 : done1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: master %0d saw no done in %0d cycles, required one", m, n);
    end
    if (drop) begin
      if (m == 0) req0_v = 1'b0;
      else        req1_v = 1'b0;
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, 64'({done0, done1, busy_o, cache_start, grant_id, cache_read_operation,
                  cache_address, cache_write_data, rdata0, rdata1}), 64'd0);
  endtask

  task automatic do_op();
    if (m_rd) cache_read_data = mem[m_addr];
    else      mem[m_addr] = m_wdata;
  endtask

  task automatic handle_done();
    sb_t e;
    int  m;
    m = done1 ? 1 : 0;
    chk("done_exclusive", 64'(done0 & done1), 64'd0);
    chk("done_width", 64'(prev_done), 64'd0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: got done from master %0d, required none", m);
    end else begin
      e = sb_q.pop_front();
      chk("done_master", 64'(m), 64'(e.master));
      chk("grant_id", 64'(grant_id), 64'(e.master));
      chk("busy_o_at_done", 64'(busy_o), 64'd1);
      chk("cache_address", 64'(cache_address), 64'(e.addr));
      chk("cache_read_operation", 64'(cache_read_operation), 64'(e.rd));
      if (!e.rd) chk("cache_write_data", 64'(cache_write_data), 64'(e.data));
      if (e.rd) exp_rdata[m] = e.data;
      chk(m == 0 ? "rdata0" : "rdata1", 64'(m == 0 ? rdata0 : rdata1), 64'(exp_rdata[m]));
      chk("start_to_done_latency", 64'(cyc - start_cyc), 64'(e.lat));
    end
    active = 1'b0;
  endtask

  // Output monitor and behavioural cache model, both on the falling edge.
  initial begin
    model_busy      = 1'b0;
    cache_read_data = '0;
    m_cnt           = 0;
    prev_start      = 1'b0;
    prev_done       = 1'b0;
    active          = 1'b0;
    exp_rdata[0]    = '0;
    exp_rdata[1]    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active       = 1'b0;
        prev_start   = 1'b0;
        prev_done    = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
      end else begin
        if (cache_start) begin
          chk("back_to_back_start", 64'(prev_start), 64'd0);
          start_cnt++;
          start_cyc = cyc;
          active    = 1'b1;
          s_addr    = cache_address;
          s_wdata   = cache_write_data;
          s_rd      = cache_read_operation;
        end else if (active) begin
          chk("payload_stable", 64'({cache_address, cache_write_data, cache_read_operation}),
              64'({s_addr, s_wdata, s_rd}));
        end
        prev_start = cache_start;
        if (done0 || done1) handle_done();
        prev_done = done0 | done1;
      end
      if (model_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          do_op();
          model_busy = 1'b0;
        end
      end else if (cache_start && !rst) begin
        m_rd    = cache_read_operation;
        m_addr  = cache_address;
        m_wdata = cache_write_data;
        if (busy_len == 0) begin
          do_op();
        end else begin
          model_busy = 1'b1;
          m_cnt      = busy_len;
        end
      end
    end
  end

  vec_t vecs[8];

  initial begin
    vec_t v;
    int   base;
    int   n;

    vecs[0] = '{1'b1, 1'b1, 8'd11, 8'h00, 1'b0, 1'b0, 8'd0,  8'h00, 6, 0};
    vecs[1] = '{1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 8'd20, 8'h33, 2, 1};
    vecs[2] = '{1'b1, 1'b0, 8'd10, 8'h07, 1'b1, 1'b1, 8'd10, 8'h00, 2, 0};
    vecs[3] = '{1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 8'd20, 8'h00, 3, 1};
    vecs[4] = '{1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 8'd10, 8'h00, 2, 1};
    vecs[5] = '{1'b1, 1'b1, 8'd20, 8'h00, 1'b1, 1'b0, 8'd11, 8'hC3, 4, 0};
    vecs[6] = '{1'b1, 1'b1, 8'd11, 8'h00, 1'b0, 1'b0, 8'd0,  8'h00, 2, 0};
    vecs[7] = '{1'b1, 1'b0, 8'd30, 8'h99, 1'b1, 1'b1, 8'd30, 8'h00, 2, 1};

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    mem[11]     = 8'h5A;
    ref_mem[11] = 8'h5A;

    rst = 1'b1; force_busy = 1'b0;
    req0_v = 1'b0; req1_v = 1'b0; rd0_v = 1'b0; rd1_v = 1'b0;
    addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table of single and contending requests.
    for (int i = 0; i < 8; i++) begin
      v        = vecs[i];
      busy_len = v.blen;
      base     = start_cnt;
      if (v.r0 && v.r1) begin
        if (v.first == 0) begin
          push(0, v.rd0, v.a0, v.w0, v.blen);
          push(1, v.rd1, v.a1, v.w1, v.blen);
        end else begin
          push(1, v.rd1, v.a1, v.w1, v.blen);
          push(0, v.rd0, v.a0, v.w0, v.blen);
        end
        n = 2;
      end else if (v.r0) begin
        push(0, v.rd0, v.a0, v.w0, v.blen);
        n = 1;
      end else begin
        push(1, v.rd1, v.a1, v.w1, v.blen);
        n = 1;
      end
      @(negedge clk);
      if (v.r0) drive(0, v.rd0, v.a0, v.w0);
      if (v.r1) drive(1, v.rd1, v.a1, v.w1);
      fork
        begin if (v.r0) wait_done(0, 1'b1); end
        begin if (v.r1) wait_done(1, 1'b1); end
      join
      repeat (2) @(negedge clk);
      chk("starts_per_vector", 64'(start_cnt - base), 64'(n));
      if (i == 0) chk("first_read_rdata0", 64'(rdata0), 64'h5A);
    end

    // Cache never reports busy: completion by timeout, data still captured.
    busy_len = 0;
    @(negedge clk);
    push(0, 1'b1, 8'd40, 8'h00, 0);
    drive(0, 1'b1, 8'd40, 8'h00);
    wait_done(0, 1'b1);
    repeat (2) @(negedge clk);

    // Cache busy across reset release with master 1 pending.
    busy_len   = 2;
    rst        = 1'b1;
    force_busy = 1'b1;
    drive(1, 1'b1, 8'd50, 8'h00);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = start_cnt;
    repeat (6) @(negedge clk);
    chk("no_start_while_busy", 64'(start_cnt - base), 64'd0);
    chk("no_grant_while_busy", 64'(busy_o), 64'd0);
    push(1, 1'b1, 8'd50, 8'h00, 2);
    force_busy = 1'b0;
    wait_done(1, 1'b1);
    repeat (2) @(negedge clk);

    // Reset while waiting on a long cache op; the request is reissued afterwards.
    busy_len = 8;
    @(negedge clk);
    push(0, 1'b1, 8'd60, 8'h00, 8);
    drive(0, 1'b1, 8'd60, 8'h00);
    n = 0;
    while (!cache_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cache_went_busy", 64'(cache_busy), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_op_outputs");
    rst  = 1'b0;
    base = start_cnt;
    wait_done(0, 1'b1);
    chk("reissue_starts", 64'(start_cnt - base), 64'd1);
    repeat (2) @(negedge clk);

    // From reset, both masters keep requesting for two transactions each.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    busy_len = 2;
    base     = start_cnt;
    push(0, 1'b0, 8'd70, 8'h11, 2);
    push(1, 1'b1, 8'd70, 8'h00, 2);
    push(0, 1'b1, 8'd70, 8'h00, 2);
    push(1, 1'b0, 8'd71, 8'h22, 2);
    @(negedge clk);
    drive(0, 1'b0, 8'd70, 8'h11);
    drive(1, 1'b1, 8'd70, 8'h00);
    fork
      begin
        wait_done(0, 1'b0);
        drive(0, 1'b1, 8'd70, 8'h00);
        wait_done(0, 1'b1);
      end
      begin
        wait_done(1, 1'b0);
        drive(1, 1'b0, 8'd71, 8'h22);
        wait_done(1, 1'b1);
      end
    join
    repeat (3) @(negedge clk);
    chk("alternating_starts", 64'(start_cnt - base), 64'd4);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
